// File: rtl/main_pkg.sv
// Shared definitions for the main_core MIPS-subset CPU: opcodes, functs,
// FSM states, ALU operations and memory geometry.
package main_pkg;

    localparam int MEM_DEPTH = 512;
    localparam int PC_W      = 9;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_MUL   = 6'b011100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLLV,
        ALU_SRLV,
        ALU_SRAV,
        ALU_SLL,
        ALU_SLTU,
        ALU_MUL
    } alu_op_t;

    function automatic logic [31:0] sext16(input logic [15:0] i_v);
        return {{16{i_v[15]}}, i_v};
    endfunction

endpackage

// File: rtl/main_alu.sv
// Combinational ALU: add/sub, bitwise logic, shifts, unsigned set-less-than
// and the low word of a multiply.
module main_alu
    import main_pkg::*;
(
    input  alu_op_t     i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [4:0]  i_shamt,
    output logic [31:0] o_y
);

    always_comb begin
        o_y = '0;
        case (i_op)
            ALU_ADD:  o_y = i_a + i_b;
            ALU_SUB:  o_y = i_a - i_b;
            ALU_AND:  o_y = i_a & i_b;
            ALU_OR:   o_y = i_a | i_b;
            ALU_XOR:  o_y = i_a ^ i_b;
            ALU_SLLV: o_y = i_a << i_b[4:0];
            ALU_SRLV: o_y = i_a >> i_b[4:0];
            ALU_SRAV: o_y = $signed(i_a) >>> i_b[4:0];
            ALU_SLL:  o_y = i_b << i_shamt;
            ALU_SLTU: o_y = {31'd0, (i_a < i_b)};
            // Low 32 bits of a product do not depend on operand signedness.
            ALU_MUL:  o_y = i_a * i_b;
            default:  o_y = '0;
        endcase
    end

endmodule

// File: rtl/main_core.sv
// Two-state multi-cycle MIPS-subset CPU with private scan-loaded 512-word
// instruction and data memories and a fully exported register file.
module main_core
    import main_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        Jen,
    input  logic [31:0] Jin,
    output logic [31:0] Jout,
    output logic        InstDone,
    output logic [31:0] R1,
    output logic [31:0] R2,
    output logic [31:0] R3,
    output logic [31:0] R4,
    output logic [31:0] R5,
    output logic [31:0] R6,
    output logic [31:0] R7,
    output logic [31:0] R8,
    output logic [31:0] R9,
    output logic [31:0] R10,
    output logic [31:0] R11,
    output logic [31:0] R12,
    output logic [31:0] R13,
    output logic [31:0] R14,
    output logic [31:0] R15,
    output logic [31:0] R16,
    output logic [31:0] R17,
    output logic [31:0] R18,
    output logic [31:0] R19,
    output logic [31:0] R20,
    output logic [31:0] R21,
    output logic [31:0] R22,
    output logic [31:0] R23,
    output logic [31:0] R24,
    output logic [31:0] R25,
    output logic [31:0] R26,
    output logic [31:0] R27,
    output logic [31:0] R28,
    output logic [31:0] R29,
    output logic [31:0] R30,
    output logic [31:0] R31
);

    state_t            r_state;
    state_t            w_state_next;
    logic              w_commit;
    logic [PC_W-1:0]   r_pc;
    logic [31:0]       r_ir;
    logic [31:0]       r_regs [0:31];
    logic [31:0]       r_hi;
    logic [31:0]       r_lo;
    logic              r_inst_done;
    logic [31:0]       r_imem [0:MEM_DEPTH-1];
    logic [31:0]       r_dmem [0:MEM_DEPTH-1];

    logic [5:0]        w_op;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [4:0]        w_shamt;
    logic [5:0]        w_funct;
    logic [31:0]       w_sext;
    logic [31:0]       w_rs_val;
    logic [31:0]       w_rt_val;
    logic [PC_W-1:0]   w_didx;
    logic [PC_W-1:0]   w_pc_inc;
    logic [PC_W-1:0]   w_br_tgt;
    logic [31:0]       w_div_q;
    logic [31:0]       w_div_r;
    logic [31:0]       w_alu_y;

    alu_op_t           w_alu_op;
    logic [31:0]       w_alu_b;
    logic              w_wb_en;
    logic [4:0]        w_wb_addr;
    logic [31:0]       w_wb_data;
    logic [PC_W-1:0]   w_pc_next;
    logic              w_dmem_we;
    logic              w_div_we;

    assign w_op     = r_ir[31:26];
    assign w_rs     = r_ir[25:21];
    assign w_rt     = r_ir[20:16];
    assign w_rd     = r_ir[15:11];
    assign w_shamt  = r_ir[10:6];
    assign w_funct  = r_ir[5:0];
    assign w_sext   = sext16(r_ir[15:0]);
    // Entry 0 is reset to zero and never written, so it reads as $zero.
    assign w_rs_val = r_regs[w_rs];
    assign w_rt_val = r_regs[w_rt];
    assign w_didx   = PC_W'((w_rs_val + w_sext) >> 2);
    assign w_pc_inc = r_pc + 9'd1;
    assign w_br_tgt = w_pc_inc + w_sext[PC_W-1:0];
    assign w_div_q  = (w_rt_val == 32'd0) ? 32'hFFFF_FFFF : (w_rs_val / w_rt_val);
    assign w_div_r  = (w_rt_val == 32'd0) ? w_rs_val : (w_rs_val % w_rt_val);

    main_alu u_alu (
        .i_op    (w_alu_op),
        .i_a     (w_rs_val),
        .i_b     (w_alu_b),
        .i_shamt (w_shamt),
        .o_y     (w_alu_y)
    );

    // Scan loading wins over execution and parks the FSM in FETCH.
    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        if (Jen) begin
            w_state_next = ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH: w_state_next = ST_EXEC;
                ST_EXEC: begin
                    w_state_next = ST_FETCH;
                    w_commit     = 1'b1;
                end
                default:  w_state_next = ST_FETCH;
            endcase
        end
    end

    always_comb begin
        w_alu_op  = ALU_ADD;
        w_alu_b   = w_rt_val;
        w_wb_en   = 1'b0;
        w_wb_addr = w_rd;
        w_wb_data = w_alu_y;
        w_pc_next = w_pc_inc;
        w_dmem_we = 1'b0;
        w_div_we  = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                case (w_funct)
                    F_ADD:  begin w_alu_op = ALU_ADD;  w_wb_en = 1'b1; end
                    F_SUB:  begin w_alu_op = ALU_SUB;  w_wb_en = 1'b1; end
                    F_AND:  begin w_alu_op = ALU_AND;  w_wb_en = 1'b1; end
                    F_OR:   begin w_alu_op = ALU_OR;   w_wb_en = 1'b1; end
                    F_XOR:  begin w_alu_op = ALU_XOR;  w_wb_en = 1'b1; end
                    F_SLLV: begin w_alu_op = ALU_SLLV; w_wb_en = 1'b1; end
                    F_SRLV: begin w_alu_op = ALU_SRLV; w_wb_en = 1'b1; end
                    F_SRAV: begin w_alu_op = ALU_SRAV; w_wb_en = 1'b1; end
                    F_SLL:  begin w_alu_op = ALU_SLL;  w_wb_en = 1'b1; end
                    F_DIV:  w_div_we = 1'b1;
                    F_MFHI: begin w_wb_data = r_hi; w_wb_en = 1'b1; end
                    F_MFLO: begin w_wb_data = r_lo; w_wb_en = 1'b1; end
                    F_JR:   w_pc_next = w_rs_val[PC_W-1:0];
                    default: ;
                endcase
            end
            OP_ADDI: begin
                w_alu_b   = w_sext;
                w_wb_addr = w_rt;
                w_wb_en   = 1'b1;
            end
            OP_SLTI: begin
                w_alu_op  = ALU_SLTU;
                w_alu_b   = w_sext;
                w_wb_addr = w_rt;
                w_wb_en   = 1'b1;
            end
            OP_MUL: begin
                w_alu_op = ALU_MUL;
                w_wb_en  = 1'b1;
            end
            OP_LW: begin
                w_wb_addr = w_rt;
                w_wb_data = r_dmem[w_didx];
                w_wb_en   = 1'b1;
            end
            OP_SW:  w_dmem_we = 1'b1;
            OP_BEQ: if (w_rs_val == w_rt_val) w_pc_next = w_br_tgt;
            OP_BNE: if (w_rs_val != w_rt_val) w_pc_next = w_br_tgt;
            OP_J:   w_pc_next = r_ir[PC_W-1:0];
            OP_JAL: begin
                w_pc_next = r_ir[PC_W-1:0];
                w_wb_addr = 5'd31;
                w_wb_data = {23'd0, w_pc_inc};
                w_wb_en   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_FETCH;
            r_pc        <= '0;
            r_ir        <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_inst_done <= 1'b0;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            r_state     <= w_state_next;
            r_inst_done <= w_commit;
            if (!Jen && r_state == ST_FETCH) r_ir <= r_imem[r_pc];
            if (w_commit) begin
                r_pc <= w_pc_next;
                if (w_wb_en && w_wb_addr != 5'd0) r_regs[w_wb_addr] <= w_wb_data;
                if (w_div_we) begin
                    r_hi <= w_div_r;
                    r_lo <= w_div_q;
                end
            end
        end
    end

    // Memories survive reset; the two arrays form one 1024-word scan chain.
    always_ff @(posedge clk) begin
        if (Jen) begin
            r_imem[0] <= Jin;
            for (int k = 1; k < MEM_DEPTH; k++) r_imem[k] <= r_imem[k-1];
            r_dmem[0] <= r_imem[MEM_DEPTH-1];
            for (int k = 1; k < MEM_DEPTH; k++) r_dmem[k] <= r_dmem[k-1];
        end else if (w_commit && w_dmem_we) begin
            r_dmem[w_didx] <= w_rt_val;
        end
    end

    assign Jout     = r_dmem[MEM_DEPTH-1];
    assign InstDone = r_inst_done;
    assign R1  = r_regs[1];
    assign R2  = r_regs[2];
    assign R3  = r_regs[3];
    assign R4  = r_regs[4];
    assign R5  = r_regs[5];
    assign R6  = r_regs[6];
    assign R7  = r_regs[7];
    assign R8  = r_regs[8];
    assign R9  = r_regs[9];
    assign R10 = r_regs[10];
    assign R11 = r_regs[11];
    assign R12 = r_regs[12];
    assign R13 = r_regs[13];
    assign R14 = r_regs[14];
    assign R15 = r_regs[15];
    assign R16 = r_regs[16];
    assign R17 = r_regs[17];
    assign R18 = r_regs[18];
    assign R19 = r_regs[19];
    assign R20 = r_regs[20];
    assign R21 = r_regs[21];
    assign R22 = r_regs[22];
    assign R23 = r_regs[23];
    assign R24 = r_regs[24];
    assign R25 = r_regs[25];
    assign R26 = r_regs[26];
    assign R27 = r_regs[27];
    assign R28 = r_regs[28];
    assign R29 = r_regs[29];
    assign R30 = r_regs[30];
    assign R31 = r_regs[31];

endmodule

// File: tb/tb_main_core.sv
// Bench for main_core: directed programs plus random programs, each checked
// against an instruction-level reference model after every retirement.
module tb_main_core;

  localparam logic [5:0] T_R = 6'b000000, T_J = 6'b000010, T_JAL = 6'b000011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_BNE = 6'b000101, T_ADDI = 6'b001000;
  localparam logic [5:0] T_SLTI = 6'b001010, T_MUL = 6'b011100, T_LW = 6'b100011;
  localparam logic [5:0] T_SW = 6'b101011;
  localparam logic [5:0] FN_SLL = 6'b000000, FN_SLLV = 6'b000100, FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111, FN_JR = 6'b001000, FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010, FN_DIV = 6'b011010, FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010, FN_AND = 6'b100100, FN_OR = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  logic clk = 1'b0;
  logic rst;
  logic jen;
  logic [31:0] jin;
  logic [31:0] jout;
  logic inst_done;
  logic [31:1][31:0] r_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_imem [512];
  logic [31:0] m_dmem [512];
  logic [31:0] m_regs [32];
  logic [31:0] m_hi, m_lo;
  int m_pc;
  logic [31:0] exp_q [$];

  main_core dut (
    .clk(clk), .rst(rst), .Jen(jen), .Jin(jin), .Jout(jout), .InstDone(inst_done),
    .R1(r_out[1]), .R2(r_out[2]), .R3(r_out[3]), .R4(r_out[4]), .R5(r_out[5]),
    .R6(r_out[6]), .R7(r_out[7]), .R8(r_out[8]), .R9(r_out[9]), .R10(r_out[10]),
    .R11(r_out[11]), .R12(r_out[12]), .R13(r_out[13]), .R14(r_out[14]), .R15(r_out[15]),
    .R16(r_out[16]), .R17(r_out[17]), .R18(r_out[18]), .R19(r_out[19]), .R20(r_out[20]),
    .R21(r_out[21]), .R22(r_out[22]), .R23(r_out[23]), .R24(r_out[24]), .R25(r_out[25]),
    .R26(r_out[26]), .R27(r_out[27]), .R28(r_out[28]), .R29(r_out[29]), .R30(r_out[30]),
    .R31(r_out[31])
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // instruction encoders
  function automatic logic [31:0] enc_r(logic [5:0] op, int rs, int rt, int rd, int sh, logic [5:0] fn);
    return {op, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(logic [5:0] op, int tgt);
    return {op, 26'(tgt)};
  endfunction

  // reference model
  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_hi = '0;
    m_lo = '0;
    m_pc = 0;
  endtask

  task automatic model_clear_mem();
    for (int i = 0; i < 512; i++) begin
      m_imem[i] = '0;
      m_dmem[i] = '0;
    end
  endtask

  task automatic model_shift(input logic [31:0] w);
    for (int k = 511; k > 0; k--) m_dmem[k] = m_dmem[k-1];
    m_dmem[0] = m_imem[511];
    for (int k = 511; k > 0; k--) m_imem[k] = m_imem[k-1];
    m_imem[0] = w;
  endtask

  task automatic wr(input int d, input logic [31:0] v);
    if (d != 0) m_regs[d] = v;
  endtask

  task automatic model_step();
    logic [31:0] ins, a, b, se, addr;
    logic signed [63:0] prod;
    logic [5:0] op, fn;
    int rs, rt, rd, sh, nxt;
    ins = m_imem[m_pc];
    op = ins[31:26];
    fn = ins[5:0];
    rs = int'(ins[25:21]);
    rt = int'(ins[20:16]);
    rd = int'(ins[15:11]);
    sh = int'(ins[10:6]);
    se = {{16{ins[15]}}, ins[15:0]};
    a = m_regs[rs];
    b = m_regs[rt];
    addr = a + se;
    nxt = (m_pc + 1) % 512;
    case (op)
      T_R: begin
        case (fn)
          FN_ADD:  wr(rd, a + b);
          FN_SUB:  wr(rd, a - b);
          FN_AND:  wr(rd, a & b);
          FN_OR:   wr(rd, a | b);
          FN_XOR:  wr(rd, a ^ b);
          FN_SLLV: wr(rd, a << b[4:0]);
          FN_SRLV: wr(rd, a >> b[4:0]);
          FN_SRAV: wr(rd, $signed(a) >>> b[4:0]);
          FN_SLL:  wr(rd, b << sh);
          FN_DIV: begin
            if (b == 0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
            else begin m_hi = a % b; m_lo = a / b; end
          end
          FN_MFHI: wr(rd, m_hi);
          FN_MFLO: wr(rd, m_lo);
          FN_JR:   nxt = int'(a % 512);
          default: ;
        endcase
      end
      T_ADDI: wr(rt, a + se);
      T_SLTI: wr(rt, (a < se) ? 32'd1 : 32'd0);
      T_MUL: begin
        prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        wr(rd, prod[31:0]);
      end
      T_LW:  wr(rt, m_dmem[(addr >> 2) % 512]);
      T_SW:  m_dmem[(addr >> 2) % 512] = b;
      T_BEQ: if (a == b) nxt = (m_pc + 1 + int'($signed(ins[15:0]))) & 511;
      T_BNE: if (a != b) nxt = (m_pc + 1 + int'($signed(ins[15:0]))) & 511;
      T_J:   nxt = int'(ins[8:0]);
      T_JAL: begin
        wr(31, 32'(m_pc + 1));
        nxt = int'(ins[8:0]);
      end
      default: ;
    endcase
    m_pc = nxt;
  endtask

  // drivers
  task automatic hold_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic scan_load();
    @(negedge clk);
    jen = 1'b1;
    for (int i = 511; i >= 0; i--) begin jin = m_dmem[i]; @(negedge clk); end
    for (int i = 511; i >= 0; i--) begin jin = m_imem[i]; @(negedge clk); end
    jen = 1'b0;
    jin = '0;
  endtask

  // Shifts DMEM out through Jout, oldest index 511 first.
  task automatic scan_dump(input string tag);
    for (int s = 0; s < 512; s++) exp_q.push_back(m_dmem[511 - s]);
    jin = '0;
    for (int s = 0; s < 512; s++) begin
      check_eq($sformatf("%s dmem[%0d]", tag, 511 - s), jout, exp_q.pop_front());
      if (s < 511) begin
        jen = 1'b1;
        @(negedge clk);
      end
    end
    jen = 1'b0;
  endtask

  task automatic compare_regs(input string tag);
    for (int r = 1; r < 32; r++)
      check_eq($sformatf("%s R%0d", tag, r), r_out[r], m_regs[r]);
  endtask

  task automatic run_insts(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      int waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (inst_done !== 1'b1 && waited < 8);
      if (inst_done !== 1'b1) begin
        check_eq($sformatf("%s pulse_timeout", tag), 32'(inst_done), 32'd1);
        return;
      end
      if (k == 0) check_eq($sformatf("%s first_latency_ge2", tag), 32'(waited >= 2), 32'd1);
      else check_eq($sformatf("%s pulse_gap", tag), 32'(waited), 32'd2);
      model_step();
      compare_regs(tag);
      check_eq($sformatf("%s Jout", tag), jout, m_dmem[511]);
    end
  endtask

  task automatic freeze(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      logic [31:0] w;
      w = gen_instr();
      jin = w;
      jen = 1'b1;
      @(negedge clk);
      model_shift(w);
      check_eq("freeze InstDone", 32'(inst_done), 32'd0);
      compare_regs("freeze");
    end
    jen = 1'b0;
    jin = '0;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [5:0] fns [12];
    int rs, rt, rd;
    fns = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLLV, FN_SRLV, FN_SRAV,
            FN_SLL, FN_DIV, FN_MFHI, FN_MFLO};
    rs = $urandom_range(0, 12);
    rt = $urandom_range(0, 12);
    rd = $urandom_range(0, 12);
    case ($urandom_range(0, 15))
      0, 1, 2, 3: return enc_r(T_R, rs, rt, rd, $urandom_range(0, 31), fns[$urandom_range(0, 11)]);
      4, 5: return enc_i(T_ADDI, rs, rt, $urandom_range(0, 65535));
      6:  return enc_i(T_SLTI, rs, rt, $urandom_range(0, 65535));
      7:  return enc_r(T_MUL, rs, rt, rd, 0, 6'd0);
      8:  return enc_i(T_LW, rs, rt, $urandom_range(0, 65535));
      9:  return enc_i(T_SW, rs, rt, $urandom_range(0, 65535));
      10: return enc_i(T_BEQ, rs, rt, int'($urandom_range(0, 8)) - 4);
      11: return enc_i(T_BNE, rs, rt, int'($urandom_range(0, 8)) - 4);
      12: return enc_j(T_J, $urandom_range(0, 47));
      13: return enc_j(T_JAL, $urandom_range(0, 47));
      14: return enc_r(T_R, 31, 0, 0, 0, FN_JR);
      default: return ($urandom_range(0, 1) == 0) ? enc_j(6'b110011, $urandom_range(0, 1000))
                                                   : enc_r(T_R, rs, rt, rd, 0, 6'b111110);
    endcase
  endfunction

  initial begin
    rst = 1'b0;
    jen = 1'b0;
    jin = '0;
    model_reset();
    repeat (3) @(negedge clk);

    // reset state
    check_eq("reset InstDone", 32'(inst_done), 32'd0);
    compare_regs("reset");

    // scan round trip
    model_clear_mem();
    for (int i = 0; i < 512; i++) m_dmem[i] = 32'(i + 'h100);
    scan_load();
    check_eq("scan Jout after load", jout, 32'h2FF);
    scan_dump("scan");
    check_eq("scan Jout after 511 shifts", jout, 32'h100);

    // basic ALU
    hold_reset();
    model_clear_mem();
    m_imem[0] = enc_i(T_ADDI, 0, 3, 5);
    m_imem[1] = enc_i(T_ADDI, 0, 4, -2);
    m_imem[2] = enc_r(T_R, 3, 4, 5, 0, FN_ADD);
    m_imem[3] = enc_r(T_R, 4, 3, 6, 0, FN_SUB);
    m_imem[4] = enc_r(T_R, 0, 3, 7, 4, FN_SLL);
    scan_load();
    release_reset();
    run_insts(5, "alu");
    check_eq("alu R3", r_out[3], 32'd5);
    check_eq("alu R4", r_out[4], 32'hFFFF_FFFE);
    check_eq("alu R5", r_out[5], 32'd3);
    check_eq("alu R6", r_out[6], 32'hFFFF_FFF9);
    check_eq("alu R7", r_out[7], 32'h50);

    // reset during EXEC of the third instruction
    hold_reset();
    release_reset();
    run_insts(2, "pre_rst");
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_eq("midrst InstDone", 32'(inst_done), 32'd0);
    compare_regs("midrst");
    release_reset();
    run_insts(5, "rerun");
    check_eq("rerun R7", r_out[7], 32'h50);

    // store loop then load
    hold_reset();
    model_clear_mem();
    m_imem[0] = enc_i(T_ADDI, 0, 4, 256);
    m_imem[1] = enc_i(T_ADDI, 0, 3, 0);
    m_imem[2] = enc_i(T_SW, 3, 3, 0);
    m_imem[3] = enc_i(T_ADDI, 3, 3, 4);
    m_imem[4] = enc_i(T_BNE, 3, 4, -3);
    m_imem[5] = enc_i(T_LW, 0, 5, 12);
    scan_load();
    release_reset();
    run_insts(195, "loop");
    check_eq("loop R5", r_out[5], 32'd12);
    hold_reset();
    scan_dump("loop");

    // mul / div
    model_clear_mem();
    m_imem[0]  = enc_i(T_ADDI, 0, 1, 7);
    m_imem[1]  = enc_i(T_ADDI, 0, 2, -3);
    m_imem[2]  = enc_r(T_MUL, 1, 2, 3, 0, 6'd0);
    m_imem[3]  = enc_i(T_ADDI, 0, 4, 17);
    m_imem[4]  = enc_i(T_ADDI, 0, 5, 5);
    m_imem[5]  = enc_r(T_R, 4, 5, 0, 0, FN_DIV);
    m_imem[6]  = enc_r(T_R, 0, 0, 6, 0, FN_MFHI);
    m_imem[7]  = enc_r(T_R, 0, 0, 7, 0, FN_MFLO);
    m_imem[8]  = enc_r(T_R, 1, 0, 0, 0, FN_DIV);
    m_imem[9]  = enc_r(T_R, 0, 0, 8, 0, FN_MFHI);
    m_imem[10] = enc_r(T_R, 0, 0, 9, 0, FN_MFLO);
    scan_load();
    release_reset();
    run_insts(11, "muldiv");
    check_eq("mul R3", r_out[3], 32'hFFFF_FFEB);
    check_eq("div hi R6", r_out[6], 32'd2);
    check_eq("div lo R7", r_out[7], 32'd3);
    check_eq("div0 hi R8", r_out[8], 32'd7);
    check_eq("div0 lo R9", r_out[9], 32'hFFFF_FFFF);

    // control flow
    hold_reset();
    model_clear_mem();
    m_imem[0]  = enc_i(T_ADDI, 0, 1, 1);
    m_imem[1]  = enc_i(T_ADDI, 0, 4, 7);
    m_imem[4]  = enc_j(T_JAL, 10);
    m_imem[5]  = enc_i(T_ADDI, 0, 2, 'h55);
    m_imem[6]  = enc_i(T_BEQ, 1, 0, 5);
    m_imem[7]  = enc_i(T_ADDI, 0, 3, -1);
    m_imem[8]  = enc_i(T_SLTI, 3, 4, 1);
    m_imem[9]  = enc_j(T_J, 9);
    m_imem[10] = enc_i(T_ADDI, 0, 6, 'h66);
    m_imem[11] = enc_r(T_R, 31, 0, 0, 0, FN_JR);
    scan_load();
    release_reset();
    run_insts(5, "ctrl");
    check_eq("jal R31", r_out[31], 32'd5);
    run_insts(7, "ctrl");
    check_eq("jr return R2", r_out[2], 32'h55);
    check_eq("beq fallthru R3", r_out[3], 32'hFFFF_FFFF);
    check_eq("slti unsigned R4", r_out[4], 32'd0);
    check_eq("jal target R6", r_out[6], 32'h66);

    // random programs with a scan freeze in the middle
    for (int it = 0; it < 3; it++) begin
      hold_reset();
      model_clear_mem();
      for (int i = 0; i < 512; i++) m_dmem[i] = $urandom;
      for (int i = 1; i <= 8; i++) m_imem[i-1] = enc_i(T_ADDI, 0, i, $urandom_range(0, 65535));
      for (int i = 8; i < 48; i++) m_imem[i] = gen_instr();
      scan_load();
      release_reset();
      run_insts(120, $sformatf("rnd%0d", it));
      freeze(3);
      run_insts(130, $sformatf("rnd%0d", it));
      hold_reset();
      scan_dump($sformatf("rnd%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/main_core.md
# main_core

Single-issue, multi-cycle 32-bit MIPS-subset CPU (`main`) with private 512-word instruction and data memories. The memories are loaded through a 32-bit-wide scan chain (`Jen`/`Jin`/`Jout`). All 31 architectural registers are exported so a bench can compare them against a reference model after every retired instruction.

## Interface
- No parameters. Memory depth is fixed at 512 words each; register width is fixed at 32 bits.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `Jen` in 1: scan-load enable; execution is frozen while high.
- `Jin` in 32: scan input word.
- `Jout` out 32: scan output, equal to DMEM[511].
- `InstDone` out 1: one-cycle pulse per retired instruction.
- `R1`…`R31` out 32 each: live register-file contents. R0 is hard-wired to 0 and not exported.

## Operation
- **Scan chain** (each rising edge with `Jen`=1):
  - IMEM[0]←Jin, IMEM[k]←IMEM[k-1], DMEM[0]←IMEM[511], DMEM[k]←DMEM[k-1].
  - A 1024-word load sent as DMEM[511]…DMEM[0] then IMEM[511]…IMEM[0] places every word at its own index.
- **Reset** clears PC, R1–R31, HI, LO, FSM state and `InstDone`; memories are untouched. Reset may be asserted before load, between load and run, or mid-execution.
- **PC**: 9-bit word index into IMEM. Sequential next PC is PC+1, wrapping mod 512.
- **Data addressing**: effective byte address rs+sext(imm); word index = (addr>>2)&511. The low two bits are ignored.
- **R-type** (opcode 000000), by funct:
  - add 100000, sub 100010, and 100100, or 100101, xor 100110 (all wrapping, no overflow trap).
  - sllv 000100: rd=rs<<rt[4:0]. srlv 000110: rd=rs>>rt[4:0]. srav 000111: arithmetic shift of rs by rt[4:0].
  - sll 000000: rd=rt<<shamt[10:6].
  - div 011010, unsigned: HI=rs%rt, LO=rs/rt. If rt=0: HI=rs, LO=0xFFFFFFFF.
  - mfhi 010000, mflo 010010.
  - jr 001000: PC=rs[8:0].
- **I/J-type**:
  - addi 001000: rt=rs+sext(imm).
  - lw 100011, sw 101011.
  - beq 000100 / bne 000101: PC=PC+1+sext(imm) when taken.
  - slti 001010: rt=1 if rs < sext(imm), compared as 32-bit **unsigned**, else 0.
  - j 000010: PC=imm[8:0].
  - jal 000011: R31=PC+1, PC=imm[8:0].
  - mul 011100: rd = low 32 bits of signed rs×rt.
- Writes to R0 are discarded.
- Unknown opcode or funct executes as a NOP and still retires.
- There is no halt: the CPU runs continuously and zero words execute as NOPs.

## Timing
- FSM has two states: FETCH (IR←IMEM[PC]) then EXEC (decode, ALU, memory access, register/HI/LO/DMEM write, PC update, all on one edge). EXEC returns to FETCH.
- Each instruction takes exactly 2 cycles.
- `InstDone` is registered:
  - Goes high on the same edge as the EXEC commit and stays high for exactly one cycle (the following FETCH).
  - Low at least one cycle between pulses.
  - Register outputs are already updated whenever `InstDone`=1.
- Reset values: `InstDone`=0, R1–R31=0, HI=LO=0, PC=0, state=FETCH.
- After reset release the first `InstDone` pulse comes no earlier than 2 edges later.
- `Jen`=1 has priority over execution: FSM holds in FETCH, PC and registers are unchanged, `InstDone`=0.
- DMEM and IMEM reads are combinational. `Jout` is combinational from DMEM[511].

## Structure
- Shared package `main_pkg`: opcode and funct localparams, FSM state enum, memory-depth constant (512).
- Natural sub-module: `main_alu`, combinational, covering add/sub/logic/shifts/slti/mul. div, HI/LO, the FSM and both memories stay in the top level.
- Target size is 200–350 lines of RTL.

## Test plan
- Scan round-trip: load DMEM[i]=i+0x100 and IMEM=0 via 1024 `Jen` cycles → `Jout`=0x2FF. Then 511 further shifts with Jin=0 → `Jout` shows 0x100 in the last of them.
- Basic ALU: IMEM=[addi $3,$0,5; addi $4,$0,-2; add $5,$3,$4; sub $6,$4,$3; sll $7,$3,4] → after each pulse, R3=5, R4=0xFFFFFFFE, R5=3, R6=0xFFFFFFF9, R7=0x50. `InstDone` pulses every 2 cycles.
- Memory and loop: store loop `sw $3,0($3)`; addi $3,$3,4; bne $3,$4,-3 with $4=256 → DMEM[k]=4k for k=0..63. A following `lw $5,12($0)` gives R5=12.
- Mul/div: rs=7, rt=-3 → mul gives 0xFFFFFFEB. div 17/5 then mfhi/mflo → 2 / 3. div by 0 → HI=rs, LO=0xFFFFFFFF.
- Control flow:
  - jal 10 from PC 4 → R31=5, PC=10.
  - jr $31 returns to 5.
  - beq not taken falls through.
  - slti with rs=0xFFFFFFFF, imm=1 → 0 (unsigned compare).
- Reset mid-run: assert `rst` low during EXEC of instruction 3 → `InstDone`=0 and R1–R31=0 immediately. Execution restarts at PC 0 with memory contents preserved.
